fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch.sv | 114 +++++++++++
 tb/tb_fetch_prefetch.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch
// Brief    : Credit-based instruction prefetcher with FWFT queue and redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(DEPTH);

  logic [31:0]   r_fpc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_ofl;
  logic [CW-1:0] r_dcnt;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];

  logic          w_empty;
  logic [CW:0]   w_credit_sum;
  logic          w_fire;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;

  assign w_empty       = (r_cnt == '0);
  assign w_credit_sum  = {1'b0, r_cnt} + {1'b0, r_ofl};
  assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};

  assign imem_req_valid_o = rstn_i && !redirect_i && (w_credit_sum < C_DEPTH);
  assign imem_req_addr_o  = r_fpc;
  assign inst_valid_o     = !w_empty && !redirect_i;

  assign w_fire = imem_req_valid_o && imem_req_ready_i;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign w_rsp  = imem_rsp_valid_i && (r_ofl != '0);
  assign w_push = w_rsp && (r_dcnt == '0) && !redirect_i;
  assign w_pop  = inst_valid_o && inst_ready_i;

  assign inst_o     = w_empty ? 32'h0 : r_q_inst[r_rd_ptr];
  assign pc_o       = w_empty ? 32'h0 : r_q_pc[r_rd_ptr];
  assign pc_plus4_o = w_empty ? 32'h0 : r_q_pc[r_rd_ptr] + 32'd4;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= imem_rsp_data_i;
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_fpc    <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_cnt    <= '0;
      r_ofl    <= '0;
      r_dcnt   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (redirect_i) begin
      r_fpc    <= w_redirect_pc;
      r_rsp_pc <= w_redirect_pc;
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_ofl    <= r_ofl - CW'(w_rsp);
      // In-flight already includes earlier stale requests, so every request
      // still outstanding after this cycle's response becomes a discard.
      r_dcnt   <= r_ofl - CW'(w_rsp);
    end else begin
      if (w_fire) begin
        r_fpc <= r_fpc + 32'd4;
      end
      r_ofl <= r_ofl + CW'(w_fire) - CW'(w_rsp);
      if (w_rsp && (r_dcnt != '0)) begin
        r_dcnt <= r_dcnt - CW'(1);
      end
      // Kept responses arrive in order, so the next kept pc is a running count.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch
// Brief    : Self-checking bench for fetch_prefetch with an in-order memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = 32'h0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .pc_plus4_o       (pc_plus4_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          checks = 0;
  int          failures = 0;

  logic        s_fire, s_valid, s_pop, s_rsp;
  logic [31:0] s_addr, s_pc, s_p4, s_inst;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock: sample just before the edge, then advance the memory model.
  task automatic step();
    #1;
    s_fire  = imem_req_valid_o && imem_req_ready_i;
    s_addr  = imem_req_addr_o;
    s_valid = inst_valid_o;
    s_pop   = inst_valid_o && inst_ready_i;
    s_pc    = pc_o;
    s_p4    = pc_plus4_o;
    s_inst  = inst_o;
    s_rsp   = imem_rsp_valid_i;
    @(posedge clk_i);
    #1;
    if (s_rsp && mq.size() > 0) void'(mq.pop_front());
    if (s_fire) begin
      mreq_t r;
      r.addr = s_addr;
      r.due  = cyc + ((mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat);
      mq.push_back(r);
    end
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = memf(mq[0].addr);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'h0;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    mq.delete();
    imem_rsp_valid_i = 1'b0;
    redirect_i       = 1'b0;
    inst_ready_i     = 1'b0;
    imem_req_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    #2 rstn_i = 1'b0;
    imem_req_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_req_valid got=%b want=0", imem_req_valid_o);
    end
    checks++;
    if (inst_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid_o);
    end
    checks++;
    if ({inst_o, pc_o, pc_plus4_o} !== 96'h0) begin
      failures++; $display("FAIL reset_outputs got=%h/%h/%h want=0", inst_o, pc_o, pc_plus4_o);
    end
  endtask

  task automatic test_basic();
    mq.delete();
    mem_lat = 1;
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (!(s_fire === 1'b1 && s_addr === 32'(4 * k))) begin
        failures++; $display("FAIL basic_req k=%0d got=%b/%h want=1/%h", k, s_fire, s_addr, 32'(4 * k));
      end
      checks++;
      if (s_valid !== (k >= 2)) begin
        failures++; $display("FAIL basic_valid k=%0d got=%b want=%b", k, s_valid, (k >= 2));
      end
      if (k >= 2) begin
        checks++;
        if (s_pc !== 32'(4 * (k - 2)) || s_p4 !== 32'(4 * (k - 1)) || s_inst !== memf(32'(4 * (k - 2)))) begin
          failures++; $display("FAIL basic_head k=%0d got=%h/%h/%h want=%h/%h/%h", k, s_pc, s_p4, s_inst,
                               32'(4 * (k - 2)), 32'(4 * (k - 1)), memf(32'(4 * (k - 2))));
        end
      end
    end
  endtask

  task automatic test_full();
    int nf;
    do_reset();
    mem_lat = 1;
    imem_req_ready_i = 1'b1;
    nf = 0;
    repeat (10) begin
      step();
      nf += int'(s_fire);
    end
    checks++;
    if (nf != DEPTH) begin
      failures++; $display("FAIL full_req_count got=%0d want=%0d", nf, DEPTH);
    end
    #1;
    checks++;
    if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b1 || pc_o !== 32'h0) begin
      failures++; $display("FAIL full_state got=%b/%b/%h want=0/1/0", imem_req_valid_o, inst_valid_o, pc_o);
    end
    inst_ready_i = 1'b1;
    step();
    checks++;
    if (s_pop !== 1'b1 || s_pc !== 32'h0 || s_fire !== 1'b0) begin
      failures++; $display("FAIL full_pop got=%b/%h/%b want=1/0/0", s_pop, s_pc, s_fire);
    end
    inst_ready_i = 1'b0;
    step();
    checks++;
    if (s_fire !== 1'b1 || s_addr !== 32'h10) begin
      failures++; $display("FAIL full_refill got=%b/%h want=1/10", s_fire, s_addr);
    end
    step();
    checks++;
    if (s_fire !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h4) begin
      failures++; $display("FAIL full_hold got=%b/%b/%h want=0/1/4", s_fire, s_valid, s_pc);
    end
  endtask

  task automatic test_redirect();
    int nf;
    logic got;
    do_reset();
    mem_lat = 5;
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    nf = 0;
    repeat (3) begin
      step();
      nf += int'(s_fire);
    end
    checks++;
    if (nf != 3) begin
      failures++; $display("FAIL redir_inflight got=%0d want=3", nf);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h103;
    step();
    redirect_i = 1'b0;
    checks++;
    if (s_fire !== 1'b0 || s_valid !== 1'b0) begin
      failures++; $display("FAIL redir_block got=%b/%b want=0/0", s_fire, s_valid);
    end
    step();
    checks++;
    if (s_fire !== 1'b1 || s_addr !== 32'h100) begin
      failures++; $display("FAIL redir_first_req got=%b/%h want=1/100", s_fire, s_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (s_valid) begin
        got = 1'b1;
        checks++;
        if (s_pc !== 32'h100 || s_p4 !== 32'h104 || s_inst !== memf(32'h100)) begin
          failures++; $display("FAIL redir_first_inst got=%h/%h/%h want=100/104/%h", s_pc, s_p4, s_inst, memf(32'h100));
        end
      end
    end
    if (!got) begin
      checks++; failures++; $display("FAIL redir_timeout got=no_inst want=inst");
    end
  endtask

  task automatic test_rsp_redirect();
    logic got;
    do_reset();
    mem_lat = 2;
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    step();
    step();
    imem_req_ready_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    step();
    redirect_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (s_valid !== 1'b0) begin
        failures++; $display("FAIL rsp_redir_empty k=%0d got=%b want=0", k, s_valid);
      end
    end
    imem_req_ready_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_valid) begin
        got = 1'b1;
        checks++;
        if (s_pc !== 32'h200 || s_inst !== memf(32'h200)) begin
          failures++; $display("FAIL rsp_redir_first got=%h/%h want=200/%h", s_pc, s_inst, memf(32'h200));
        end
      end
    end
    if (!got) begin
      checks++; failures++; $display("FAIL rsp_redir_timeout got=no_inst want=inst");
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem_lat = 1;
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    step();
    redirect_i = 1'b0;
    step();
    checks++;
    if (s_fire !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_req0 got=%b/%h want=1/fffffffc", s_fire, s_addr);
    end
    step();
    checks++;
    if (s_fire !== 1'b1 || s_addr !== 32'h0) begin
      failures++; $display("FAIL wrap_req1 got=%b/%h want=1/0", s_fire, s_addr);
    end
    step();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'hFFFF_FFFC || s_p4 !== 32'h0 || s_inst !== memf(32'hFFFF_FFFC)) begin
      failures++; $display("FAIL wrap_head0 got=%b/%h/%h want=1/fffffffc/0", s_valid, s_pc, s_p4);
    end
    step();
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_p4 !== 32'h4) begin
      failures++; $display("FAIL wrap_head1 got=%b/%h/%h want=1/0/4", s_valid, s_pc, s_p4);
    end
  endtask

  task automatic test_reset_mid();
    logic got;
    do_reset();
    mem_lat = 3;
    imem_req_ready_i = 1'b1;
    repeat (5) step();
    rstn_i = 1'b0;
    #1;
    checks++;
    if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_o !== 32'h0 || inst_o !== 32'h0) begin
      failures++; $display("FAIL midrst_clear got=%b/%b/%h/%h want=0/0/0/0", imem_req_valid_o, inst_valid_o, pc_o, inst_o);
    end
    imem_req_ready_i = 1'b0;
    step();
    rstn_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (s_valid !== 1'b0) begin
        failures++; $display("FAIL midrst_late_rsp k=%0d got=%b want=0", k, s_valid);
      end
    end
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    step();
    checks++;
    if (s_fire !== 1'b1 || s_addr !== RESET_PC) begin
      failures++; $display("FAIL midrst_first_req got=%b/%h want=1/%h", s_fire, s_addr, RESET_PC);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_valid) begin
        got = 1'b1;
        checks++;
        if (s_pc !== RESET_PC || s_inst !== memf(RESET_PC)) begin
          failures++; $display("FAIL midrst_first_inst got=%h/%h want=%h/%h", s_pc, s_inst, RESET_PC, memf(RESET_PC));
        end
      end
    end
    if (!got) begin
      checks++; failures++; $display("FAIL midrst_timeout got=no_inst want=inst");
    end
  endtask

  // Reference: fetch and decode each see a linear +4 address stream that
  // restarts at the aligned target on every redirect.
  task automatic test_random();
    logic [31:0] exp_fetch, exp_dec, tgt;
    logic        redir;
    int          npops;
    do_reset();
    mem_lat = 0;
    exp_fetch = RESET_PC;
    exp_dec   = RESET_PC;
    npops = 0;
    for (int i = 0; i < 800; i++) begin
      inst_ready_i     = ($urandom_range(0, 3) != 0);
      imem_req_ready_i = ($urandom_range(0, 3) != 0);
      redir            = ($urandom_range(0, 29) == 0);
      tgt              = $urandom;
      redirect_i       = redir;
      redirect_pc_i    = tgt;
      step();
      if (redir) begin
        checks++;
        if (s_fire !== 1'b0 || s_valid !== 1'b0) begin
          failures++; $display("FAIL rand_redir_block i=%0d got=%b/%b want=0/0", i, s_fire, s_valid);
        end
        exp_fetch = {tgt[31:2], 2'b00};
        exp_dec   = {tgt[31:2], 2'b00};
      end else begin
        if (s_fire) begin
          checks++;
          if (s_addr !== exp_fetch) begin
            failures++; $display("FAIL rand_req_addr i=%0d got=%h want=%h", i, s_addr, exp_fetch);
          end
          exp_fetch = exp_fetch + 32'd4;
        end
        if (s_pop) begin
          checks++;
          if (s_pc !== exp_dec || s_p4 !== exp_dec + 32'd4 || s_inst !== memf(exp_dec)) begin
            failures++; $display("FAIL rand_inst i=%0d got=%h/%h/%h want=%h/%h/%h", i, s_pc, s_p4, s_inst,
                                 exp_dec, exp_dec + 32'd4, memf(exp_dec));
          end
          exp_dec = exp_dec + 32'd4;
          npops++;
        end
      end
    end
    redirect_i = 1'b0;
    checks++;
    if (npops < 100) begin
      failures++; $display("FAIL rand_progress got=%0d want>=100", npops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_redirect();
    test_rsp_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
